// File: rtl/video_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_scanout: 640x480@60 timing, PPU row/frame handshakes, and a 3-stage |
// | row/palette read pipeline driving 2x-doubled RGB to the HDMI transmitter. |
// | Optional bar test pattern: define VIDEO_SCANOUT_TESTPAT_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VIDEO_SCANOUT_TESTPAT_EN
  input  logic        testpat,
`endif
  output logic [8:0]  rowram_rdaddr,
  input  logic [9:0]  rowram_rddata,
  output logic [8:0]  palram_rdaddr,
  input  logic [63:0] palram_rddata,
  output logic        rowram_swap,
  output logic        vblank_start,
  output logic        vblank_end,
  output logic [7:0]  vid_r,
  output logic [7:0]  vid_g,
  output logic [7:0]  vid_b,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de
);

  localparam logic [9:0] c_H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] c_H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] c_V_LAST_ACT   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] c_V_LAST_SWAP  = 10'(V_ACTIVE - 3);
  localparam logic [9:0] c_V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] c_V_END_LINE   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 2);
  localparam logic [9:0] c_V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;
  logic        w_de_raw;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_swap_line;
  logic [1:0]  r_de_d;
  logic [1:0]  r_hs_d;
  logic [1:0]  r_vs_d;
  logic        r_sel;
  logic [23:0] w_colour;
  logic        w_unused_pal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= c_V_ACT;
    end else if (r_hcount == c_H_LAST) begin
      r_hcount <= '0;
      r_vcount <= (r_vcount == c_V_LAST) ? '0 : r_vcount + 10'd1;
    end else begin
      r_hcount <= r_hcount + 10'd1;
    end
  end

  assign w_de_raw = (r_hcount < c_H_ACT) && (r_vcount < c_V_ACT);
  assign w_hs_raw = !((r_hcount >= c_H_SYNC_START) && (r_hcount < c_H_SYNC_END));
  assign w_vs_raw = !((r_vcount >= c_V_SYNC_START) && (r_vcount < c_V_SYNC_END));

  // Row 0 is presented on the last blank line; later rows swap on odd lines so
  // each buffer is shown for two lines. The final active line never swaps.
  assign w_swap_line = (r_vcount == c_V_LAST) ||
                       (r_vcount[0] && (r_vcount <= c_V_LAST_SWAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_start <= 1'b0;
      vblank_end   <= 1'b0;
      rowram_swap  <= 1'b0;
    end else begin
      vblank_start <= (r_hcount == c_H_ACT) && (r_vcount == c_V_LAST_ACT);
      vblank_end   <= (r_hcount == 10'd0) && (r_vcount == c_V_END_LINE);
      rowram_swap  <= (r_hcount == c_H_ACT) && w_swap_line;
    end
  end

  assign rowram_rdaddr = w_de_raw ? r_hcount[9:1] : 9'd0;
  assign palram_rdaddr = rowram_rddata[9:1];
  assign w_unused_pal  = ^{palram_rddata[63:56], palram_rddata[31:24]};

`ifdef VIDEO_SCANOUT_TESTPAT_EN
  logic [9:0] r_h_d1;
  logic [9:0] r_h_d2;
  logic [2:0] w_bar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_d1 <= '0;
      r_h_d2 <= '0;
    end else begin
      r_h_d1 <= r_hcount;
      r_h_d2 <= r_h_d1;
    end
  end

  always_comb begin
    w_bar = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (r_h_d2 < 10'((i + 1) * 80)) w_bar = 3'(i);
    end
  end

  // Bar order white..black maps each component to an inverted index bit.
  always_comb begin
    w_colour = r_sel ? palram_rddata[55:32] : palram_rddata[23:0];
    if (testpat) begin
      w_colour = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
    end
  end
`else
  assign w_colour = r_sel ? palram_rddata[55:32] : palram_rddata[23:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= 1'b0;
      r_de_d <= 2'b00;
      r_hs_d <= 2'b11;
      r_vs_d <= 2'b11;
      vid_de <= 1'b0;
      vid_hs <= 1'b1;
      vid_vs <= 1'b1;
      vid_r  <= '0;
      vid_g  <= '0;
      vid_b  <= '0;
    end else begin
      r_sel  <= rowram_rddata[0];
      r_de_d <= {r_de_d[0], w_de_raw};
      r_hs_d <= {r_hs_d[0], w_hs_raw};
      r_vs_d <= {r_vs_d[0], w_vs_raw};
      vid_de <= r_de_d[1];
      vid_hs <= r_hs_d[1];
      vid_vs <= r_vs_d[1];
      if (r_de_d[1]) begin
        vid_r <= w_colour[23:16];
        vid_g <= w_colour[15:8];
        vid_b <= w_colour[7:0];
      end else begin
        vid_r <= '0;
        vid_g <= '0;
        vid_b <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_scanout: directed self-checking bench for video_scanout, with a  |
// | shortened vertical frame. Revision: 1.0                                    |
// +----------------------------------------------------------------------------+
module tb_video_scanout;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 8, VF = 3, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  rowram_rdaddr;
  logic [9:0]  rowram_rddata = '0;
  logic [8:0]  palram_rdaddr;
  logic [63:0] palram_rddata = '0;
  logic        rowram_swap, vblank_start, vblank_end;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic        vid_hs, vid_vs, vid_de;
`ifdef VIDEO_SCANOUT_TESTPAT_EN
  logic        testpat = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int th, tv;

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VIDEO_SCANOUT_TESTPAT_EN
    .testpat(testpat),
`endif
    .rowram_rdaddr(rowram_rdaddr),
    .rowram_rddata(rowram_rddata),
    .palram_rdaddr(palram_rdaddr),
    .palram_rddata(palram_rddata),
    .rowram_swap(rowram_swap),
    .vblank_start(vblank_start),
    .vblank_end(vblank_end),
    .vid_r(vid_r),
    .vid_g(vid_g),
    .vid_b(vid_b),
    .vid_hs(vid_hs),
    .vid_vs(vid_vs),
    .vid_de(vid_de)
  );

  always #5 clk = ~clk;

  // RAM models: row k holds {k, k[0]}; palette word w holds two tagged colours.
  always @(posedge clk) begin
    rowram_rddata <= {rowram_rdaddr, rowram_rdaddr[0]};
    palram_rddata <= {8'h00, 24'hA00000 | {15'd0, palram_rdaddr},
                      8'h00, 24'h0000B0 | {15'd0, palram_rdaddr}};
  end

  // Reference scan position, following the timing definition.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th <= 0;
      tv <= VA;
    end else if (th == HT - 1) begin
      th <= 0;
      tv <= (tv == VT - 1) ? 0 : tv + 1;
    end else begin
      th <= th + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] pal_pix(input int x);
    int k;
    logic [23:0] w;
    k = x >> 1;
    w = 24'(k);
    return (k % 2 == 1) ? (24'hA00000 | w) : (24'h0000B0 | w);
  endfunction

  function automatic logic [23:0] bar_pix(input int x);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[x / 80];
  endfunction

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(th == h && tv == v) && n < 2 * HT * VT) begin
      @(negedge clk);
      n++;
    end
    if (!(th == h && tv == v)) begin
      $display("FAIL goto: position h=%0d v=%0d never reached", h, v);
      $fatal(1);
    end
  endtask

  task automatic wait_first_vbe(input string tag);
    int n;
    int vbs;
    n = 0;
    vbs = 0;
    while (!vblank_end && n < 2 * HT * VT) begin
      @(negedge clk);
      n++;
      if (vblank_start) vbs++;
    end
    check({tag, "_vbe_latency"}, 64'(n), 64'((VT - 2 - VA) * HT + 1));
    check({tag, "_no_vbs"}, 64'(vbs), 64'd0);
  endtask

  int s_vbs, s_vbe, s_swap, s_coinc, s_de, s_hsl, s_hsf, s_vsl, s_bad;
  int vbs_pos, vbe_pos, swap0_h, de_pos, vs_pos;

  task automatic sweep_frame(input bit tp);
    logic        prev_hs;
    logic [23:0] exp;
    s_vbs = 0; s_vbe = 0; s_swap = 0; s_coinc = 0; s_de = 0;
    s_hsl = 0; s_hsf = 0; s_vsl = 0; s_bad = 0;
    vbs_pos = -1; vbe_pos = -1; swap0_h = -1; de_pos = -1; vs_pos = -1;
    goto(0, 0);
    prev_hs = vid_hs;
    for (int i = 0; i < HT * VT; i++) begin
      if (vblank_start) begin s_vbs++; vbs_pos = th * 1000 + tv; end
      if (vblank_end) begin s_vbe++; vbe_pos = th * 1000 + tv; end
      if (rowram_swap) begin
        s_swap++;
        if (tv == VT - 1) swap0_h = th;
        if (vblank_start) s_coinc++;
      end
      if (vid_de) begin
        s_de++;
        if (de_pos < 0) de_pos = th * 1000 + tv;
      end
      if (!vid_hs) s_hsl++;
      if (prev_hs && !vid_hs) s_hsf++;
      prev_hs = vid_hs;
      if (!vid_vs) begin
        s_vsl++;
        if (vs_pos < 0) vs_pos = th * 1000 + tv;
      end
      if (tv < VA && th >= 3 && th < HA + 3) begin
        exp = tp ? bar_pix(th - 3) : pal_pix(th - 3);
        if (!vid_de || {vid_r, vid_g, vid_b} !== exp) s_bad++;
      end else if (vid_de || {vid_r, vid_g, vid_b} != 24'd0) begin
        s_bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_sweep(input string tag);
    check({tag, "_vbs_count"}, 64'(s_vbs), 64'd1);
    check({tag, "_vbe_count"}, 64'(s_vbe), 64'd1);
    check({tag, "_swap_count"}, 64'(s_swap), 64'(VA / 2));
    check({tag, "_swap_vbs_overlap"}, 64'(s_coinc), 64'd0);
    check({tag, "_vbs_pos"}, 64'(vbs_pos), 64'((HA + 1) * 1000 + VA - 1));
    check({tag, "_vbe_pos"}, 64'(vbe_pos), 64'(1000 + VT - 2));
    check({tag, "_swap0_h"}, 64'(swap0_h), 64'(HA + 1));
    check({tag, "_de_cycles"}, 64'(s_de), 64'(HA * VA));
    check({tag, "_de_first"}, 64'(de_pos), 64'(3000));
    check({tag, "_hs_low_cycles"}, 64'(s_hsl), 64'(HS * VT));
    check({tag, "_hs_falls"}, 64'(s_hsf), 64'(VT));
    check({tag, "_vs_low_cycles"}, 64'(s_vsl), 64'(VS * HT));
    check({tag, "_vs_first"}, 64'(vs_pos), 64'(3000 + VA + VF));
    check({tag, "_pixel_errors"}, 64'(s_bad), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, 64'(vid_hs), 64'd1);
    check({tag, "_vs"}, 64'(vid_vs), 64'd1);
    check({tag, "_de"}, 64'(vid_de), 64'd0);
    check({tag, "_rgb"}, 64'({vid_r, vid_g, vid_b}), 64'd0);
    check({tag, "_pulses"}, 64'({vblank_start, vblank_end, rowram_swap}), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_rowaddr", 64'(rowram_rdaddr), 64'd0);

    rst_n = 1'b1;
    wait_first_vbe("start");

    sweep_frame(1'b0);
    check_sweep("frame");

    goto(2, 2);   check("l2_h2_de", 64'(vid_de), 64'd0);
    goto(3, 2);   check("l2_h3_de", 64'(vid_de), 64'd1);
                  check("l2_h3_rgb", 64'({vid_r, vid_g, vid_b}), 64'h0000B0);
    goto(10, 2);  check("l2_h10_rowaddr", 64'(rowram_rdaddr), 64'd5);
    goto(11, 2);  check("l2_h11_paladdr", 64'(palram_rdaddr), 64'd5);
    goto(12, 2);  check("l2_h12_rgb", 64'({vid_r, vid_g, vid_b}), 64'h0000B4);
    goto(13, 2);  check("l2_h13_de", 64'(vid_de), 64'd1);
                  check("l2_h13_rgb", 64'({vid_r, vid_g, vid_b}), 64'hA00005);
    goto(642, 2); check("l2_h642_rgb", 64'({vid_r, vid_g, vid_b}), 64'hA0013F);
    goto(643, 2); check("l2_h643_de", 64'(vid_de), 64'd0);
                  check("l2_h643_rgb", 64'({vid_r, vid_g, vid_b}), 64'd0);
    goto(645, 2); check("l2_h645_de", 64'(vid_de), 64'd0);
                  check("l2_h645_rgb", 64'({vid_r, vid_g, vid_b}), 64'd0);
    goto(658, 2); check("l2_h658_hs", 64'(vid_hs), 64'd1);
    goto(659, 2); check("l2_h659_hs", 64'(vid_hs), 64'd0);
    goto(700, 2); check("l2_h700_rowaddr", 64'(rowram_rdaddr), 64'd0);
    goto(754, 2); check("l2_h754_hs", 64'(vid_hs), 64'd0);
    goto(755, 2); check("l2_h755_hs", 64'(vid_hs), 64'd1);

    goto(300, 5);
    check("midframe_de_before", 64'(vid_de), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_first_vbe("rerun");

`ifdef VIDEO_SCANOUT_TESTPAT_EN
    testpat = 1'b1;
    sweep_frame(1'b1);
    check_sweep("testpat");
    testpat = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
